// File: rtl/uart_cmd_framer.sv
// Collects UART RX bytes into fixed-length command frames, checks opcode == end byte,
// and hands validated frames to the decoder over valid/ready with timeout resync and drop accounting.
module uart_cmd_framer #(
  parameter int FRAME_BYTES    = 18,
  parameter int CLK_FREQ       = 103_340_000,
  parameter int TIMEOUT_CYCLES = CLK_FREQ / 100,
  parameter int CNT_BITS       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [8*FRAME_BYTES-1:0] frame_out,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic                     err_mismatch,
  output logic                     err_timeout,
  output logic [CNT_BITS-1:0]      drop_count,
  output logic                     busy
);

  localparam int FW = 8 * FRAME_BYTES;
  localparam int CW = $clog2(FRAME_BYTES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_CHECK   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [FW-1:0]       asm_q, asm_d;
  logic [FW-1:0]       out_q, out_d;
  logic                fv_q, fv_d;
  logic                mis_q, mis_d;
  logic                tmo_err_q, tmo_err_d;
  logic [CNT_BITS-1:0] drop_q, drop_d;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    count_d   = count_q;
    tmo_d     = tmo_q;
    asm_d     = asm_q;
    out_d     = out_q;
    fv_d      = fv_q;
    mis_d     = 1'b0;
    tmo_err_d = 1'b0;
    drop_d    = drop_q;

    if (fv_q && frame_ready) fv_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          asm_d[7:0] = rx_data;
          count_d    = CW'(1);
          tmo_d      = '0;
          state_d    = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (rx_valid) begin
          asm_d[8*int'(count_q) +: 8] = rx_data;
          count_d = count_q + CW'(1);
          tmo_d   = '0;
          if (count_q == LAST_IDX) state_d = S_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          count_d   = '0;
          tmo_d     = '0;
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_CHECK: begin
        // A transfer this cycle frees the output, so a new frame may load in its place.
        if (asm_q[FW-1 -: 8] != asm_q[7:0]) begin
          mis_d = 1'b1;
        end else if (!fv_q || frame_ready) begin
          out_d = asm_q;
          fv_d  = 1'b1;
        end else if (drop_q != '1) begin
          drop_d = drop_q + CNT_BITS'(1);
        end

        if (rx_valid) begin
          asm_d[7:0] = rx_data;
          count_d    = CW'(1);
          tmo_d      = '0;
          state_d    = S_COLLECT;
        end else begin
          count_d = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        count_d = '0;
        tmo_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      tmo_q     <= '0;
      asm_q     <= '0;
      out_q     <= '0;
      fv_q      <= 1'b0;
      mis_q     <= 1'b0;
      tmo_err_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tmo_q     <= tmo_d;
      asm_q     <= asm_d;
      out_q     <= out_d;
      fv_q      <= fv_d;
      mis_q     <= mis_d;
      tmo_err_q <= tmo_err_d;
      drop_q    <= drop_d;
    end
  end

  assign frame_out    = out_q;
  assign frame_valid  = fv_q;
  assign err_mismatch = mis_q;
  assign err_timeout  = tmo_err_q;
  assign drop_count   = drop_q;
  assign busy         = (count_q != '0);

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Scoreboard bench for uart_cmd_framer: expected frames are queued at stimulus time and
// popped by a monitor on every frame_valid & frame_ready transfer.
module tb_uart_cmd_framer;

  localparam int FB = 18;
  localparam int FW = 8 * FB;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [FW-1:0] frame_out;
  logic          frame_valid;
  logic          frame_ready;
  logic          err_mismatch;
  logic          err_timeout;
  logic [7:0]    drop_count;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int mis_seen = 0;
  int tmo_seen = 0;
  logic [FW-1:0] exp_q[$];

  uart_cmd_framer #(
    .FRAME_BYTES(FB),
    .CLK_FREQ(10_000),
    .TIMEOUT_CYCLES(100),
    .CNT_BITS(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_out(frame_out),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .err_mismatch(err_mismatch),
    .err_timeout(err_timeout),
    .drop_count(drop_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] fill, input logic [7:0] last);
    logic [FW-1:0] f;
    for (int i = 0; i < FB; i++) f[8*i +: 8] = fill;
    f[7:0]         = b0;
    f[15:8]        = b1;
    f[8*(FB-1) +: 8] = last;
    return f;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the byte has been sampled.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [FW-1:0] f, input int nbytes);
    for (int i = 0; i < nbytes; i++) send_byte(f[8*i +: 8]);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", FW'(exp_q.size()), '0);
  endtask

  always @(negedge clk) begin
    if (err_mismatch) mis_seen++;
    if (err_timeout) tmo_seen++;
    if (!reset && frame_valid && frame_ready) begin
      check("xfer_expected", FW'(exp_q.size() != 0), FW'(1));
      if (exp_q.size() != 0) check("xfer_frame", frame_out, exp_q.pop_front());
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] fa, fb, fc, fd;
    reset       = 1'b1;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    frame_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_frame_valid", FW'(frame_valid), '0);
    check("rst_frame_out", frame_out, '0);
    check("rst_busy", FW'(busy), '0);
    check("rst_drop", FW'(drop_count), '0);
    check("rst_errs", FW'({err_mismatch, err_timeout}), '0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: basic frame with latency and handshake
    fa = mk(8'h41, 8'h42, 8'h00, 8'h41);
    exp_q.push_back(fa);
    send_frame(fa, FB);
    check("t1_busy_in_check", FW'(busy), FW'(1));
    check("t1_not_yet_valid", FW'(frame_valid), '0);
    @(posedge clk);
    #1;
    check("t1_valid", FW'(frame_valid), FW'(1));
    check("t1_byte0", FW'(frame_out[7:0]), FW'(8'h41));
    check("t1_byte1", FW'(frame_out[15:8]), FW'(8'h42));
    check("t1_byte17", FW'(frame_out[143:136]), FW'(8'h41));
    @(posedge clk);
    #1;
    check("t1_valid_drop", FW'(frame_valid), '0);

    // 2: mismatch frame, then a good one
    send_frame(mk(8'h42, 8'h11, 8'h11, 8'h43), FB);
    check("t2_mis_early", FW'(err_mismatch), '0);
    @(posedge clk);
    #1;
    check("t2_mis_pulse", FW'(err_mismatch), FW'(1));
    check("t2_no_valid", FW'(frame_valid), '0);
    @(posedge clk);
    #1;
    check("t2_mis_clear", FW'(err_mismatch), '0);
    fb = mk(8'h42, 8'h11, 8'h11, 8'h42);
    exp_q.push_back(fb);
    send_frame(fb, FB);
    wait_drain();

    // 3: timeout after 5 bytes, boundary at exactly 100 idle cycles
    send_frame(mk(8'h99, 8'h98, 8'h97, 8'h99), 5);
    repeat (99) @(posedge clk);
    #1;
    check("t3_no_tmo_at_99", FW'(err_timeout), '0);
    check("t3_busy_at_99", FW'(busy), FW'(1));
    @(posedge clk);
    #1;
    check("t3_tmo_pulse", FW'(err_timeout), FW'(1));
    check("t3_busy_clear", FW'(busy), '0);
    @(posedge clk);
    #1;
    check("t3_tmo_clear", FW'(err_timeout), '0);
    fc = mk(8'h55, 8'h66, 8'h77, 8'h55);
    exp_q.push_back(fc);
    send_frame(fc, FB);
    wait_drain();

    // 5: ready raised in the CHECK cycle of frame 2 replaces the pending frame
    frame_ready = 1'b0;
    fc = mk(8'h61, 8'h62, 8'h63, 8'h61);
    fd = mk(8'h71, 8'h72, 8'h73, 8'h71);
    exp_q.push_back(fc);
    exp_q.push_back(fd);
    send_frame(fc, FB);
    @(posedge clk);
    #1;
    check("t5_first_held", frame_out, fc);
    send_frame(fd, FB);
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t5_valid_stays", FW'(frame_valid), FW'(1));
    check("t5_out_frame2", frame_out, fd);
    check("t5_drop_unchanged", FW'(drop_count), '0);
    wait_drain();

    // 4: output occupied, drops counted and saturated
    frame_ready = 1'b0;
    fa = mk(8'h10, 8'h11, 8'h12, 8'h10);
    fb = mk(8'h20, 8'h21, 8'h22, 8'h20);
    exp_q.push_back(fa);
    send_frame(fa, FB);
    send_frame(fb, FB);
    @(posedge clk);
    #1;
    check("t4_held_out", frame_out, fa);
    check("t4_held_valid", FW'(frame_valid), FW'(1));
    check("t4_drop_one", FW'(drop_count), FW'(1));
    for (int i = 0; i < 300; i++) begin
      send_frame(fb, FB);
      if (i == 252) begin
        @(posedge clk);
        #1;
        check("t4_drop_254", FW'(drop_count), FW'(254));
      end
    end
    @(posedge clk);
    #1;
    check("t4_drop_sat", FW'(drop_count), FW'(255));
    check("t4_still_held", frame_out, fa);

    // 6: reset mid-frame with a pending frame
    send_frame(mk(8'h30, 8'h31, 8'h32, 8'h30), 10);
    check("t6_busy_pre", FW'(busy), FW'(1));
    check("t6_valid_pre", FW'(frame_valid), FW'(1));
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("t6_rst_valid", FW'(frame_valid), '0);
    check("t6_rst_out", frame_out, '0);
    check("t6_rst_busy", FW'(busy), '0);
    check("t6_rst_drop", FW'(drop_count), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    frame_ready = 1'b1;
    fd = mk(8'h5A, 8'h01, 8'h02, 8'h5A);
    exp_q.push_back(fd);
    send_frame(fd, FB);
    wait_drain();

    repeat (3) @(posedge clk);
    #1;
    check("mismatch_pulses", FW'(mis_seen), FW'(1));
    check("timeout_pulses", FW'(tmo_seen), FW'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_framer.md
Name: uart_cmd_framer

Overview:
- Assembles the byte stream from the UART receiver into fixed-length command frames.
- Validates each frame: the first (opcode) byte must equal the last (end) byte.
- Presents validated frames to the command decoder through a valid/ready handshake.
- Sits between the UART RX byte output and the command decoder. It replaces loose FIFO-snapshot framing with inter-byte timeout resync, drop accounting and error pulses.

Parameters:
- FRAME_BYTES, 18, bytes per command frame; must be >= 2.
- CLK_FREQ, 103_340_000, clock frequency in Hz.
- TIMEOUT_CYCLES, CLK_FREQ/100, idle cycles between bytes after which a partial frame is discarded (about 10 ms).
- CNT_BITS, 8, width of the saturating drop/error counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- frame_out  out  8*FRAME_BYTES  assembled frame; byte i (0 = first received) at [8*i+7:8*i].
- frame_valid  out  1  frame_out holds a validated frame.
- frame_ready  in  1  decoder accepts frame_out.
- err_mismatch  out  1  one-cycle pulse: frame completed but end byte != opcode byte.
- err_timeout  out  1  one-cycle pulse: partial frame discarded on timeout.
- drop_count  out  CNT_BITS  saturating count of valid frames dropped because the output was still occupied.
- busy  out  1  high while a partial frame is being collected (byte count != 0).

Behaviour:
- Reset (async, active-high) clears:
  - frame_out = 0, frame_valid = 0;
  - err_mismatch = 0, err_timeout = 0, drop_count = 0, busy = 0;
  - the assembly buffer, byte counter and timeout counter;
  - the state, to IDLE.
- Storage: two registers.
  - The assembly buffer is written byte by byte.
  - The output register (frame_out) is loaded as a whole frame only.
- States:
  - IDLE (count = 0): rx_valid stores the byte at index 0, sets count = 1, goes to COLLECT and clears the timeout counter.
  - COLLECT:
    - rx_valid stores the byte at index count, increments count and clears the timeout counter.
    - Without rx_valid, the timeout counter increments.
    - When the timeout counter reaches TIMEOUT_CYCLES-1 with no rx_valid that cycle: discard the partial frame, pulse err_timeout for one cycle, return to IDLE.
    - When the byte at index FRAME_BYTES-1 is received: go to CHECK.
  - CHECK (one cycle):
    - Compare byte[FRAME_BYTES-1] with byte[0].
    - If unequal: pulse err_mismatch and discard the frame.
    - If equal and the output is free (frame_valid = 0, or frame_ready = 1 this cycle): load frame_out and set frame_valid = 1.
    - If equal and the output is occupied: discard the frame and increment drop_count, saturating at all-ones.
    - In every case, return to IDLE.
- An rx_valid arriving during CHECK is accepted as byte 0 of the next frame; the transition goes to COLLECT with count = 1.
- Latency: frame_valid rises 2 cycles after the rx_valid of the final byte (1 cycle to CHECK, 1 cycle to register).
- Handshake:
  - frame_valid stays high, and frame_out stays stable, until a cycle with frame_valid & frame_ready.
  - That transfer clears frame_valid next cycle, unless a new frame loads in the same cycle, in which case frame_valid stays 1 and frame_out takes the new frame.
- rx_valid and timeout expiry in the same cycle: the byte wins; no timeout, the counter clears.
- The timeout counter is only active in COLLECT and never runs in IDLE.
- Width: the timeout counter is $clog2(TIMEOUT_CYCLES)+1 bits; the byte counter is $clog2(FRAME_BYTES)+1 bits.
- Reset asserted mid-frame or with frame_valid high: everything is cleared immediately and the pending frame is lost.

Test Plan:
1. FRAME_BYTES=18. Send 'A','B', 15×0x00, 'A' back-to-back with frame_ready=1 → 2 cycles after the last byte: frame_valid=1, frame_out[7:0]=0x41, [15:8]=0x42, [143:136]=0x41; frame_valid drops the next cycle.
2. Send 'B', 16×0x11, 'C' → err_mismatch pulses for exactly 1 cycle; frame_valid stays 0; next valid frame 'B'…'B' is accepted normally.
3. TIMEOUT_CYCLES=100. Send 5 bytes, then idle 100 cycles → err_timeout pulses once, busy=0; a following complete 18-byte frame is accepted with byte 0 = the first new byte.
4. Hold frame_ready=0. Deliver two valid frames → the first is held on frame_out, the second is dropped, drop_count=1. Deliver 300 more frames → drop_count saturates at 255.
5. Hold frame_ready=0 with frame 1 pending; raise frame_ready in the CHECK cycle of frame 2 → frame_valid stays 1, frame_out = frame 2, drop_count unchanged.
6. Assert reset after 10 bytes of a frame and while frame_valid=1 → all outputs are 0 immediately; after release, a fresh 18-byte frame is assembled from index 0.
